// File: rtl/gray_to_bin_serial.sv
// Serial Gray-to-binary decoder: one prefix-XOR bit per clock, MSB first; result valid WIDTH edges after accept.
// Backpressure: in_ready drops while converting, and while a finished result waits for out_ready.
module gray_to_bin_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy
);

  localparam int            IW      = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic             upper_bit;
  logic             cur_bit;

  // In DONE a consumer taking the result frees the slot on the same edge.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == S_CONV);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;

  always_comb begin
    upper_bit = 1'b0;
    if (idx_q != IDX_MSB) begin
      upper_bit = acc_q[idx_q + 1'b1];
    end
    cur_bit = upper_bit ^ g_q[idx_q];
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    acc_d       = acc_q;
    bin_d       = bin_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_CONV: begin
        acc_d[idx_q] = cur_bit;
        if (idx_q == '0) begin
          bin_d       = acc_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      g_d     = gray_in;
      acc_d   = '0;
      idx_d   = IDX_MSB;
      state_d = S_CONV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      acc_q       <= '0;
      bin_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      acc_q       <= acc_d;
      bin_q       <= bin_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/gray_to_bin_serial.md
Name: gray_to_bin_serial

Overview:
- Sequential Gray-to-binary decoder.
- It is the receive-side counterpart of the team's combinational binary-to-Gray encoder (D[n-1]=B[n-1], D[i]=B[i+1]^B[i]).
- It accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves the prefix-XOR chain serially, one bit per clock, MSB first.
- It presents the binary result on a registered valid/ready output port. This is for lab datapaths that carry Gray-coded counters or pointers.

Parameters:
- WIDTH, 4, word width in bits. Legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  input  1  gray_in holds a word to decode.
- in_ready  output  1  block can accept a word this cycle.
- gray_in  input  WIDTH  Gray-coded word; sampled only on the accept edge.
- out_valid  output  1  bin_out holds a completed result.
- out_ready  input  1  downstream consumes the result this cycle.
- bin_out  output  WIDTH  decoded binary word. Registered, and stable while out_valid=1.
- busy  output  1  high in CONV state.

Behaviour:
- Reset values (async assert, and held while rst=1):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; bin_out=0.
  - Internal gray register, accumulator and bit index all 0.
- Accept event: in_valid & in_ready at a rising edge.
- State IDLE:
  - in_ready=1.
  - On accept: latch gray_in into g_reg, set idx=WIDTH-1, go to CONV.
- State CONV:
  - in_ready=0, busy=1. One bit resolved per edge.
  - acc[idx] = g_reg[idx] when idx=WIDTH-1; otherwise acc[idx] = acc[idx+1] ^ g_reg[idx].
  - idx decrements each edge.
  - On the edge that resolves bit 0, load the completed word into bin_out, set out_valid=1 and go to DONE.
  - CONV lasts exactly WIDTH edges.
- State DONE:
  - out_valid=1; bin_out is held unchanged until the result is consumed.
  - in_ready = out_ready, which is combinational pass-through.
  - out_ready=1 and in_valid=0: out_valid drops to 0 next edge, go to IDLE.
  - out_ready=1 and in_valid=1 on the same edge: the result is consumed and the new word accepted on that edge. Go directly to CONV, out_valid=0. This gives back-to-back throughput of one word per WIDTH+1 cycles.
  - out_ready=0: stay in DONE indefinitely. bin_out and out_valid are held.
- Latency: accept at edge k gives out_valid=1 immediately after edge k+WIDTH.
- Held inputs:
  - gray_in is ignored outside the accept edge.
  - Changes to gray_in during CONV must not affect the result.
- in_valid while busy: not accepted (in_ready=0). The upstream must hold its word until in_ready=1.
- Reset mid-operation:
  - Asserting rst in CONV or DONE aborts immediately, with no clock edge needed.
  - All outputs return to their reset values, and any in-flight or unconsumed word is discarded.
  - First accept is possible on the first edge after rst deasserts.
- Width rules:
  - idx is $clog2(WIDTH) bits wide; there is no wrap, because the state leaves CONV when idx=0.
  - No arithmetic overflow is possible; the decode is XOR only.
- Invariant: decode(encode(x)) = x for every x in 0..2^WIDTH-1.

Test Plan:
- Basic decode (WIDTH=4): accept gray_in=0110 with out_ready=1 → out_valid rises exactly 4 edges after accept with bin_out=0100; back to IDLE one edge later.
- Boundary words: gray_in=0000 → bin_out=0000; gray_in=1000 → bin_out=1111; gray_in=0001 → bin_out=0001.
- Backpressure and back-to-back:
  - gray_in=1011 decodes to 1101, then out_ready is held 0 for 5 cycles → bin_out stays 1101, out_valid stays 1 and in_ready stays 0.
  - Then out_ready=1 with in_valid=1 and gray_in=0101 → same-edge handoff; next result 0110 is valid 4 edges later.
- Input stability: after accepting gray_in=1100, toggle gray_in to 0011 every cycle during CONV → bin_out=1000 is unaffected.
- Reset mid-conversion: assert rst 2 cycles after accepting gray_in=1111 → out_valid=0, in_ready=1 and bin_out=0000 without a clock edge. After release, accept gray_in=0010 → bin_out=0011.
- Exhaustive round-trip: for i=0..15, drive gray_in=i^(i>>1) with random out_ready stalls → bin_out=i in order, no drops, no duplicates.
